logic_alu_pipe: RTL

Parametrised, two-stage pipelined logical ALU: executes AND/EOR/ORR/BIC/MOV/MVN/TST/TEQ on `r2` and an optionally shifted `r3`, writes result `r1` and maintains an architectural NZCV flag register. It is the successor to the single-op combinational logic units. It sits between the operand-read stage and the writeback arbiter, with a valid/ready handshake on both sides.

---
 rtl/logic_alu_pipe.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/logic_alu_pipe.sv
// logic_alu_pipe: two-stage elastic pipelined logical ALU with an NZCV flag register.
// S1 holds the offered operation; S2 holds the computed result and write-enable.
// Flags are architectural: they update on the edge an op moves from S1 into S2.
// Optional feature macro: LOGIC_ALU_SHIFT_EN enables the LSL barrel shifter on r3
// and its carry-out. Without it, sh is ignored and the carry flag is never modified.
module logic_alu_pipe #(
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             s,
  input  logic [SHW-1:0]   sh,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r1,
  output logic             wr,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_EOR = 3'b001;
  localparam logic [2:0] OP_ORR = 3'b010;
  localparam logic [2:0] OP_BIC = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_MVN = 3'b101;
  localparam logic [2:0] OP_TST = 3'b110;
  localparam logic [2:0] OP_TEQ = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic             s;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r3;
  } s1_payload_t;

  s1_payload_t      s1_q;
  logic             s1_valid;

  logic             s2_advance_c;
  logic [WIDTH-1:0] op2_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             test_op_c;
  logic             flag_we_c;

  // Handshake: S2 drains when empty or consumed; S1 refills whenever it empties or moves on.
  assign s2_advance_c = !out_valid || out_ready;
  assign in_ready     = !s1_valid || s2_advance_c;

`ifdef LOGIC_ALU_SHIFT_EN
  logic [WIDTH:0] shift_ext_c;

  // LSL with one extra bit on top so the last bit shifted out lands at index WIDTH.
  always_comb begin
    shift_ext_c = {1'b0, s1_q.r3} << s1_q.sh;
    op2_c       = shift_ext_c[WIDTH-1:0];
    carry_c     = c;
    if (s1_q.sh != '0) begin
      carry_c = shift_ext_c[WIDTH];
    end
  end
`else
  logic unused_sh_c;

  // No shifter: second operand passes straight through and carry is retained.
  always_comb begin
    op2_c   = s1_q.r3;
    carry_c = c;
  end

  assign unused_sh_c = ^s1_q.sh;
`endif

  // Logical result and flag/write-back qualifiers for the op sitting in S1.
  always_comb begin
    res_c     = '0;
    test_op_c = (s1_q.op == OP_TST) || (s1_q.op == OP_TEQ);
    flag_we_c = s1_q.s || test_op_c;
    case (s1_q.op)
      OP_AND:  res_c = s1_q.r2 & op2_c;
      OP_EOR:  res_c = s1_q.r2 ^ op2_c;
      OP_ORR:  res_c = s1_q.r2 | op2_c;
      OP_BIC:  res_c = s1_q.r2 & ~op2_c;
      OP_MOV:  res_c = op2_c;
      OP_MVN:  res_c = ~op2_c;
      OP_TST:  res_c = s1_q.r2 & op2_c;
      OP_TEQ:  res_c = s1_q.r2 ^ op2_c;
      default: res_c = '0;
    endcase
  end

  // Stage 1: capture the offered operation whenever the slot is free or moving on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q.op <= op;
        s1_q.s  <= s;
        s1_q.sh <= sh;
        s1_q.r2 <= r2;
        s1_q.r3 <= r3;
      end
    end
  end

  // Stage 2: register result and write-enable; empty slot leaves old data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      r1        <= '0;
      wr        <= 1'b0;
    end else if (s2_advance_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        r1 <= res_c;
        wr <= !test_op_c;
      end
    end
  end

  // Architectural flags: written in program order as each op enters S2; V is never altered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n <= 1'b0;
      z <= 1'b0;
      c <= 1'b0;
      v <= 1'b0;
    end else if (s2_advance_c && s1_valid && flag_we_c) begin
      n <= res_c[WIDTH-1];
      z <= (res_c == '0);
      c <= carry_c;
      v <= v;
    end
  end

endmodule
